// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
// Request side is registered in the master; ready/rdata come back from memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Turns a single-cycle MemRead/MemWrite into a req/ready bus transaction, stalling the core
// until DONE; handles byte enables, store lane replication, load extension and error flags.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ALUResult,
  input  logic [31:0]              WriteData,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               funct3,
  load_store_unit_if.master        bus,
  output logic [31:0]              ReadData,
  output logic                     Stall,
  output logic                     MisalignedErr,
  output logic                     BusErr
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;

  // Size decode: funct3[1:0] 00 = byte, 01 = half, anything else = word.
  logic        is_byte, is_half, misaligned, request;
  logic [3:0]  be_st;
  logic [31:0] wdata_st;
  logic [31:0] lane_sh, ext;

  assign request = MemRead | MemWrite;
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

  always_comb begin
    misaligned = 1'b0;
    be_st      = 4'b1111;
    wdata_st   = WriteData;
    if (is_byte) begin
      be_st    = 4'b0001 << ALUResult[1:0];
      wdata_st = {4{WriteData[7:0]}};
    end else if (is_half) begin
      misaligned = ALUResult[0];
      be_st      = 4'b0011 << ALUResult[1:0];
      wdata_st   = {2{WriteData[15:0]}};
    end else begin
      misaligned = (ALUResult[1:0] != 2'b00);
    end
  end

  // Extension uses the latched lane and size, not the live inputs.
  always_comb begin
    lane_sh = bus.mem_rdata >> {lane_q, 3'b000};
    if (f3_q[1:0] == 2'b00) begin
      ext = f3_q[2] ? {24'd0, lane_sh[7:0]} : {{24{lane_sh[7]}}, lane_sh[7:0]};
    end else if (f3_q[1:0] == 2'b01) begin
      ext = f3_q[2] ? {16'd0, lane_sh[15:0]} : {{16{lane_sh[15]}}, lane_sh[15:0]};
    end else begin
      ext = bus.mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (request) begin
          if (misaligned) begin
            state_d = StDone;
            mis_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = StAccess;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALUResult[31:2], 2'b00};
            be_d    = MemWrite ? be_st : 4'b1111;
            wdata_d = wdata_st;
            lane_d  = ALUResult[1:0];
            f3_d    = funct3;
            cnt_d   = '0;
          end
        end
      end
      StAccess: begin
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
          if (!we_q) rdata_d = ext;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          berr_d  = 1'b1;
          rdata_d = 32'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      lane_q  <= 2'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign Stall         = ((state_q == StIdle) & request) | (state_q == StAccess);
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign ReadData      = rdata_q;
  assign MisalignedErr = mis_q;
  assign BusErr        = berr_q;

endmodule
